singleportram_bank: RTL and testbench

- Parametrised single-port synchronous RAM. Next generation of the 8x8 single-port RAM used in the memory exercises.
- Adds configurable width and depth, a request enable, per-byte write enables, and a selectable 1- or 2-cycle read latency with a valid strobe.
- Adds a post-reset clear sequencer that writes INIT_VALUE to every word before the RAM accepts requests.
- Intended as the generic storage bank behind register files and small buffers.

---
 rtl/singleportram_bank.sv | 153 +++++++++++++++
 tb/tb_singleportram_bank.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/singleportram_bank.sv
// singleportram_bank
//   Parametrised single-port synchronous RAM bank. It has per-byte write
//   enables and a selectable 1- or 2-cycle registered read path. After every
//   reset a clear sequencer writes INIT_VALUE to each word. No request is
//   accepted until that sweep completes.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   en         request strobe; accepted only while busy is low
//   wr         1 = write, 0 = read (sampled with en)
//   select     word address
//   in         write data
//   be         byte write enables, bit i gates in[8i+7:8i]
//   out        read data; holds its last value between reads
//   out_valid  one-cycle pulse per accepted read, aligned with out
//   busy       high while the clear sequencer runs
module singleportram_bank #(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           ADDR_WIDTH   = 3,
  parameter int unsigned           READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      wr,
  input  logic [ADDR_WIDTH-1:0]     select,
  input  logic [DATA_WIDTH-1:0]     in,
  input  logic [DATA_WIDTH/8-1:0]   be,
  output logic [DATA_WIDTH-1:0]     out,
  output logic                      out_valid,
  output logic                      busy
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic                    r_busy;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_accept;
  logic                    w_rd;
  logic                    w_wr;
  logic [NUM_BYTES-1:0]    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;
  logic [DATA_WIDTH-1:0]   w_mem_wdata;

  assign w_accept = (r_state == ST_READY) && en;
  assign w_rd     = w_accept && !wr;
  assign w_wr     = w_accept && wr;
  assign busy     = r_busy;

  // The single write port is shared by the clear sweep and user writes. The
  // state machine guarantees that they never overlap. A reset cycle never
  // writes.
  always_comb begin
    w_mem_we    = '0;
    w_mem_addr  = select;
    w_mem_wdata = in;
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        w_mem_we    = '1;
        w_mem_addr  = r_clr_cnt;
        w_mem_wdata = INIT_VALUE;
      end else if (w_wr) begin
        w_mem_we = be;
      end
    end
  end

  // The storage array is kept free of reset so that it maps onto plain RAM.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NUM_BYTES; b++) begin
      if (w_mem_we[b]) begin
        r_mem[w_mem_addr][8*b +: 8] <= w_mem_wdata[8*b +: 8];
      end
    end
  end

  // Clear sequencer / request gate
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (&r_clr_cnt) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end
        end
        ST_READY: begin
          r_state <= ST_READY;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_CLEAR;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Read path. The array is read at the edge that accepts the request, so a
  // read issued right after a write to the same word sees the new data.
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_p1_data;
      logic                  r_p1_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_p1_valid <= 1'b0;
          out_valid  <= 1'b0;
          out        <= '0;
        end else begin
          r_p1_valid <= w_rd;
          if (w_rd) begin
            r_p1_data <= r_mem[select];
          end
          out_valid <= r_p1_valid;
          if (r_p1_valid) begin
            out <= r_p1_data;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          out       <= '0;
        end else begin
          out_valid <= w_rd;
          if (w_rd) begin
            out <= r_mem[select];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_singleportram_bank.sv
// Scoreboard bench for singleportram_bank. Two instances run in lockstep on
// the same stimulus:
//   dut_a : defaults (8-bit, depth 8, latency 1, INIT 0)
//   dut_b : 16-bit, depth 8, latency 2, INIT 16'h5A5A
// A word-array model predicts read data and delivery edges into per-instance
// queues. A negedge monitor pops and compares on out_valid.
module tb_singleportram_bank;

  logic        clk;
  logic        rst;
  logic        en;
  logic        wr;
  logic [2:0]  sel;
  logic [15:0] din;
  logic [1:0]  be;

  logic [7:0]  out_a;
  logic        ov_a;
  logic        busy_a;
  logic [15:0] out_b;
  logic        ov_b;
  logic        busy_b;

  singleportram_bank dut_a (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .select(sel),
    .in(din[7:0]), .be(be[0]), .out(out_a), .out_valid(ov_a), .busy(busy_a)
  );

  singleportram_bank #(
    .DATA_WIDTH(16), .ADDR_WIDTH(3), .READ_LATENCY(2), .INIT_VALUE(16'h5A5A)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .select(sel),
    .in(din), .be(be), .out(out_b), .out_valid(ov_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    int unsigned due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int          checks   = 0;
  int          failures = 0;
  int unsigned edge_cnt = 0;
  logic        rst_q    = 1'b0;
  bit          started  = 1'b0;

  // reference model
  logic [15:0] mmem [2][8];
  int          clear_left [2];
  logic [15:0] last_out [2];
  int unsigned lat  [2] = '{1, 2};
  int unsigned nb   [2] = '{1, 2};
  logic [15:0] init [2] = '{16'h0000, 16'h5A5A};

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_q    <= rst;
  end

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d @edge %0d: got %0h expected %0h", name, d, edge_cnt, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  function automatic exp_t qpop(input int d);
    if (d == 0) return q0.pop_front();
    else        return q1.pop_front();
  endfunction

  task automatic qpush(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic qclear(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic check_dut(input int d, input logic v, input logic [15:0] o);
    exp_t e;
    if (rst_q) begin
      chk("reset_out_valid", d, {31'd0, v}, 32'd0);
      chk("reset_out", d, {16'd0, o}, 32'd0);
      qclear(d);
      last_out[d] = '0;
    end else if (v) begin
      if (qsize(d) == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_valid dut%0d @edge %0d: got out_valid=1 out=%0h expected no read pending",
                 d, edge_cnt, o);
        last_out[d] = o;
      end else begin
        e = qpop(d);
        chk("read_data", d, {16'd0, o}, {16'd0, e.data});
        chk("read_latency_edge", d, edge_cnt, e.due);
        last_out[d] = e.data;
      end
    end else begin
      chk("out_hold", d, {16'd0, o}, {16'd0, last_out[d]});
      if (qsize(d) != 0) begin
        e = qfront(d);
        if (e.due <= edge_cnt) begin
          checks++;
          failures++;
          $display("FAIL missing_valid dut%0d @edge %0d: got out_valid=0 expected data %0h due at edge %0d",
                   d, edge_cnt, e.data, e.due);
          e = qpop(d);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_q) started = 1'b1;
    if (started) begin
      check_dut(0, ov_a, {8'h00, out_a});
      check_dut(1, ov_b, out_b);
    end
  end

  // One clock of stimulus: apply the model's view of the upcoming edge, then
  // drive the edge and check busy.
  task automatic step(input logic r, input logic e, input logic w,
                      input logic [2:0] a, input logic [15:0] dt, input logic [1:0] b);
    exp_t x;
    rst = r; en = e; wr = w; sel = a; din = dt; be = b;
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        for (int k = 0; k < 8; k++) mmem[d][k] = init[d];
        clear_left[d] = 8;
      end else if (clear_left[d] > 0) begin
        clear_left[d]--;
      end else if (e) begin
        if (w) begin
          for (int k = 0; k < 2; k++)
            if (k < int'(nb[d]) && b[k]) mmem[d][a][8*k +: 8] = dt[8*k +: 8];
        end else begin
          x.data = mmem[d][a];
          x.due  = edge_cnt + lat[d];
          qpush(d, x);
        end
      end
    end
    @(posedge clk);
    #1;
    chk("busy", 0, {31'd0, busy_a}, {31'd0, clear_left[0] > 0});
    chk("busy", 1, {31'd0, busy_b}, {31'd0, clear_left[1] > 0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 2'b00);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; wr = 1'b0; sel = '0; din = '0; be = '0;
    last_out[0] = '0; last_out[1] = '0;
    clear_left[0] = 0; clear_left[1] = 0;

    // reset, then requests during clear must be ignored
    step(1'b1, 1'b1, 1'b1, 3'd3, 16'h7777, 2'b11);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 3'd3, 16'h7777, 2'b11);

    // read back the cleared contents
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 3'(i), 16'hFFFF, 2'b11);

    // fill and read back
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 3'(i), 16'h3434, 2'b11);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 3'(i), 16'h0000, 2'b00);
    idle(2);

    // byte enables
    step(1'b0, 1'b1, 1'b1, 3'd2, 16'hABCD, 2'b11);
    step(1'b0, 1'b1, 1'b1, 3'd2, 16'h1200, 2'b10);
    step(1'b0, 1'b1, 1'b1, 3'd2, 16'hFFFF, 2'b00);
    step(1'b0, 1'b1, 1'b0, 3'd2, 16'h0000, 2'b11);
    idle(2);

    // pipelined reads after writes, and read right after write
    step(1'b0, 1'b1, 1'b1, 3'd0, 16'h1111, 2'b11);
    step(1'b0, 1'b1, 1'b1, 3'd1, 16'h2222, 2'b11);
    step(1'b0, 1'b1, 1'b1, 3'd2, 16'h3333, 2'b11);
    step(1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 2'b00);
    step(1'b0, 1'b1, 1'b0, 3'd1, 16'h0000, 2'b00);
    step(1'b0, 1'b1, 1'b0, 3'd2, 16'h0000, 2'b00);
    step(1'b0, 1'b1, 1'b1, 3'd5, 16'hC3A5, 2'b11);
    step(1'b0, 1'b1, 1'b0, 3'd5, 16'h0000, 2'b00);
    idle(3);

    // reset with a read in flight, then reset again at clear cycle 4
    step(1'b0, 1'b1, 1'b0, 3'd1, 16'h0000, 2'b00);
    step(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 3'(i), 16'h0000, 2'b00);
    step(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 2'b00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 3'(i), 16'hEEEE, 2'b11);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 3'(i), 16'h0000, 2'b00);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0,
           ($urandom % 4) != 0,
           $urandom_range(0, 1) == 1,
           3'($urandom),
           16'($urandom),
           2'($urandom));
    end

    // drain and confirm nothing is left outstanding
    idle(4);
    chk("drain_empty", 0, qsize(0), 32'd0);
    chk("drain_empty", 1, qsize(1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
